// File: rtl/opiso_op_scheduler_pkg.sv
// Shared types and helpers for the operand-isolating op scheduler.
package opiso_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [1:0] OP_SEL1 = 2'd0;
  localparam logic [1:0] OP_SEL2 = 2'd1;
  localparam logic [1:0] OP_SEL3 = 2'd2;
  localparam logic [1:0] OP_SEL4 = 2'd3;

  localparam int unsigned DEF_DW = 4;
  localparam int unsigned DEF_RW = 8;

  // 2-bit op code to one-hot datapath select {sel4,sel3,sel2,sel1}
  function automatic logic [3:0] op_decode(input logic [1:0] op);
    logic [3:0] sel;
    sel = '0;
    case (op)
      OP_SEL1: sel = 4'b0001;
      OP_SEL2: sel = 4'b0010;
      OP_SEL3: sel = 4'b0100;
      OP_SEL4: sel = 4'b1000;
      default: sel = '0;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/opiso_op_scheduler_if.sv
// Request, datapath and response bundle of the op scheduler.
// slave: scheduler side; master: requesters / datapath / response sink.
interface opiso_op_scheduler_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned DW    = opiso_pkg::DEF_DW,
  parameter int unsigned RW    = opiso_pkg::DEF_RW
) ();
  localparam int unsigned IW = $clog2(N_REQ);

  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_ready;
  logic [N_REQ*DW-1:0] req_a;
  logic [N_REQ*DW-1:0] req_b;
  logic [N_REQ*2-1:0]  req_op;

  logic [DW-1:0]       dp_a;
  logic [DW-1:0]       dp_b;
  logic [3:0]          dp_sel;
  logic [RW-1:0]       dp_out;

  logic                rsp_valid;
  logic                rsp_ready;
  logic [IW-1:0]       rsp_id;
  logic [RW-1:0]       rsp_data;

  modport slave (
    input  req_valid, req_a, req_b, req_op, dp_out, rsp_ready,
    output req_ready, dp_a, dp_b, dp_sel, rsp_valid, rsp_id, rsp_data
  );

  modport master (
    output req_valid, req_a, req_b, req_op, dp_out, rsp_ready,
    input  req_ready, dp_a, dp_b, dp_sel, rsp_valid, rsp_id, rsp_data
  );

endinterface

// File: rtl/opiso_op_scheduler_rr_arb.sv
// Round-robin arbiter: first asserted request at or above ptr, with wrap.
module opiso_rr_arb #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IW-1:0]    idx,
  output logic             any
);

  // Scan N_REQ positions starting at ptr; first hit wins
  always_comb begin
    int unsigned cand;
    cand  = 0;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = 32'(ptr) + i;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!any && req[cand[IW-1:0]]) begin
        any                = 1'b1;
        grant[cand[IW-1:0]] = 1'b1;
        idx                = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/opiso_op_scheduler.sv
// Op scheduler: round-robin grants N_REQ requesters onto one shared 4-op
// datapath, drives operands/select only for the execute window, captures the
// result and returns it with the requester id over valid/ready.
// Build option OPSCHED_ISOLATION_EN: zero dp_a/dp_b/dp_sel outside EXEC;
// otherwise they keep the last issued values.
module opiso_op_scheduler
  import opiso_pkg::*;
#(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned DW       = DEF_DW,
  parameter int unsigned RW       = DEF_RW,
  parameter int unsigned PIPE_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  opiso_op_scheduler_if.slave  bus,
  output logic                 idle
);

  localparam int unsigned IW = $clog2(N_REQ);
  localparam int unsigned CW = (PIPE_LAT < 1) ? 1 : $clog2(PIPE_LAT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(PIPE_LAT);

  state_t           state, state_nxt;
  logic [IW-1:0]    rr_ptr;
  logic [IW-1:0]    cur_id;
  logic [CW-1:0]    cnt;
  logic [N_REQ-1:0] win_grant;
  logic [IW-1:0]    win_idx;
  logic             win_any;
  logic             hs;
  logic [DW-1:0]    win_a, win_b;
  logic [1:0]       win_op;

  opiso_rr_arb #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_arb (
    .req   (bus.req_valid),
    .ptr   (rr_ptr),
    .grant (win_grant),
    .idx   (win_idx),
    .any   (win_any)
  );

  // Select the winning requester's operands and op code
  always_comb begin
    win_a  = '0;
    win_b  = '0;
    win_op = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (win_idx == IW'(i)) begin
        win_a  = bus.req_a[i*DW +: DW];
        win_b  = bus.req_b[i*DW +: DW];
        win_op = bus.req_op[i*2 +: 2];
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state, handshake and status outputs
  always_comb begin
    state_nxt     = state;
    hs            = 1'b0;
    idle          = 1'b0;
    bus.req_ready = '0;
    bus.rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        idle = 1'b1;
        if (!rst) bus.req_ready = win_grant;
        if (win_any) begin
          hs        = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        if (cnt == CNT_LAST) state_nxt = RESP;
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The dp_* registers double as the latched operands: loaded at the
  // handshake so they are live for every EXEC cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr       <= '0;
      cur_id       <= '0;
      cnt          <= '0;
      bus.dp_a     <= '0;
      bus.dp_b     <= '0;
      bus.dp_sel   <= '0;
      bus.rsp_id   <= '0;
      bus.rsp_data <= '0;
    end else begin
      if (hs) begin
        bus.dp_a   <= win_a;
        bus.dp_b   <= win_b;
        bus.dp_sel <= op_decode(win_op);
        cur_id     <= win_idx;
        cnt        <= '0;
        rr_ptr     <= (win_idx == IW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
      end
      if (state == EXEC) begin
        if (cnt == CNT_LAST) begin
          bus.rsp_data <= bus.dp_out;
          bus.rsp_id   <= cur_id;
          cnt          <= '0;
`ifdef OPSCHED_ISOLATION_EN
          bus.dp_a     <= '0;
          bus.dp_b     <= '0;
          bus.dp_sel   <= '0;
`endif
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_opiso_op_scheduler.sv
// Directed bench for opiso_op_scheduler with a registered PIPE_LAT=1
// datapath model: sel1=a+b, sel2=a-b, sel3=a*b, sel4={a,b}.
module tb_opiso_op_scheduler;

`ifdef OPSCHED_ISOLATION_EN
  localparam bit ISO = 1'b1;
`else
  localparam bit ISO = 1'b0;
`endif

  logic clk;
  logic rst;
  logic idle;
  int   n_tests;
  int   n_fail;

  opiso_op_scheduler_if #(.N_REQ(4), .DW(4), .RW(8)) bus ();

  opiso_op_scheduler #(
    .N_REQ    (4),
    .DW       (4),
    .RW       (8),
    .PIPE_LAT (1)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .idle (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered datapath model
  always_ff @(posedge clk) begin
    case (bus.dp_sel)
      4'b0001: bus.dp_out <= 8'(bus.dp_a) + 8'(bus.dp_b);
      4'b0010: bus.dp_out <= 8'(bus.dp_a) - 8'(bus.dp_b);
      4'b0100: bus.dp_out <= 8'(bus.dp_a) * 8'(bus.dp_b);
      4'b1000: bus.dp_out <= {bus.dp_a, bus.dp_b};
      default: bus.dp_out <= '0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_req(input int unsigned i, input logic [3:0] a, input logic [3:0] b,
                         input logic [1:0] op);
    bus.req_a[i*4 +: 4]  = a;
    bus.req_b[i*4 +: 4]  = b;
    bus.req_op[i*2 +: 2] = op;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_op    = '0;
    bus.rsp_ready = 1'b0;

    // Reset state
    tick(); tick();
    settle();
    chk("rst_idle",      32'(idle),          32'd1);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_id",    32'(bus.rsp_id),    32'd0);
    chk("rst_rsp_data",  32'(bus.rsp_data),  32'd0);
    chk("rst_dp_a",      32'(bus.dp_a),      32'd0);
    chk("rst_dp_b",      32'(bus.dp_b),      32'd0);
    chk("rst_dp_sel",    32'(bus.dp_sel),    32'd0);
    rst = 1'b0;
    tick();

    // Single request: req0 8*2
    set_req(0, 4'd8, 4'd2, 2'd2);
    bus.req_valid = 4'b0001;
    settle();
    chk("s1_ready", 32'(bus.req_ready), 32'b0001);
    tick();
    bus.req_valid = '0;
    for (int k = 0; k < 2; k++) begin
      settle();
      chk("s1_dp_sel", 32'(bus.dp_sel), 32'b0100);
      chk("s1_dp_a",   32'(bus.dp_a),   32'd8);
      chk("s1_dp_b",   32'(bus.dp_b),   32'd2);
      chk("s1_busy",   32'(idle),       32'd0);
      chk("s1_novalid", 32'(bus.rsp_valid), 32'd0);
      tick();
    end
    settle();
    chk("s1_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("s1_rsp_data",  32'(bus.rsp_data),  32'd16);
    chk("s1_rsp_id",    32'(bus.rsp_id),    32'd0);
    chk("s1_resp_sel",  32'(bus.dp_sel),    ISO ? 32'd0 : 32'b0100);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    settle();
    chk("s1_back_idle", 32'(idle),          32'd1);
    chk("s1_rsp_drop",  32'(bus.rsp_valid), 32'd0);

    // All four requesters from reset: order 0,1,2,3,0
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    for (int unsigned i = 0; i < 4; i++) set_req(i, 4'(i + 1), 4'd3, 2'd0);
    bus.req_valid = 4'b1111;
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      settle();
      chk("rr_grant", 32'(bus.req_ready), 32'd1 << (k % 4));
      tick();
      if (k == 4) bus.req_valid = '0;
      tick();
      tick();
      settle();
      chk("rr_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("rr_rsp_id",    32'(bus.rsp_id),    32'(k % 4));
      chk("rr_rsp_data",  32'(bus.rsp_data),  32'((k % 4) + 4));
      tick();
    end
    bus.rsp_ready = 1'b0;

    // Backpressure: req1 2-8 = 0xFA held while rsp_ready low; req3 waits
    set_req(1, 4'd2, 4'd8, 2'd1);
    bus.req_valid = 4'b0010;
    settle();
    chk("bp_grant1", 32'(bus.req_ready), 32'b0010);
    tick();
    set_req(3, 4'd1, 4'd1, 2'd0);
    bus.req_valid = 4'b1000;
    settle();
    chk("bp_exec_ready", 32'(bus.req_ready), 32'd0);
    tick(); tick();
    for (int k = 0; k < 5; k++) begin
      settle();
      chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("bp_rsp_data",  32'(bus.rsp_data),  32'hFA);
      chk("bp_rsp_id",    32'(bus.rsp_id),    32'd1);
      chk("bp_ready_low", 32'(bus.req_ready), 32'd0);
      tick();
    end
    bus.rsp_ready = 1'b1;
    settle();
    chk("bp_accept_cycle_ready", 32'(bus.req_ready), 32'd0);
    tick();
    bus.rsp_ready = 1'b0;
    settle();
    chk("bp_idle_after",  32'(idle),          32'd1);
    chk("bp_grant3",      32'(bus.req_ready), 32'b1000);
    tick();
    bus.req_valid = '0;
    tick(); tick();
    settle();
    chk("bp_r3_data", 32'(bus.rsp_data), 32'd2);
    chk("bp_r3_id",   32'(bus.rsp_id),   32'd3);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;

    // Isolation: req0 sel4 a=8 b=2
    set_req(0, 4'd8, 4'd2, 2'd3);
    bus.req_valid = 4'b0001;
    settle();
    chk("iso_grant0", 32'(bus.req_ready), 32'b0001);
    tick();
    bus.req_valid = '0;
    settle();
    chk("iso_exec_sel", 32'(bus.dp_sel), 32'b1000);
    chk("iso_exec_a",   32'(bus.dp_a),   32'd8);
    tick(); tick();
    settle();
    chk("iso_rsp_data", 32'(bus.rsp_data), 32'h82);
    chk("iso_resp_sel", 32'(bus.dp_sel),   ISO ? 32'd0 : 32'b1000);
    chk("iso_resp_a",   32'(bus.dp_a),     ISO ? 32'd0 : 32'd8);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      settle();
      chk("iso_idle",     32'(idle),       32'd1);
      chk("iso_idle_sel", 32'(bus.dp_sel), ISO ? 32'd0 : 32'b1000);
      chk("iso_idle_a",   32'(bus.dp_a),   ISO ? 32'd0 : 32'd8);
      chk("iso_idle_b",   32'(bus.dp_b),   ISO ? 32'd0 : 32'd2);
      tick();
    end

    // Reset during the second EXEC cycle (rr_ptr is 1 beforehand)
    set_req(0, 4'd1, 4'd1, 2'd0);
    set_req(1, 4'd1, 4'd1, 2'd0);
    bus.req_valid = 4'b0001;
    settle();
    chk("mr_grant0", 32'(bus.req_ready), 32'b0001);
    tick();
    bus.req_valid = '0;
    tick();
    settle();
    chk("mr_exec2_a", 32'(bus.dp_a), 32'd1);
    rst = 1'b1;
    tick();
    settle();
    chk("mr_idle",      32'(idle),          32'd1);
    chk("mr_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("mr_dp_a",      32'(bus.dp_a),      32'd0);
    chk("mr_dp_b",      32'(bus.dp_b),      32'd0);
    chk("mr_dp_sel",    32'(bus.dp_sel),    32'd0);
    chk("mr_rsp_data",  32'(bus.rsp_data),  32'd0);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      settle();
      chk("mr_no_rsp", 32'(bus.rsp_valid), 32'd0);
    end
    bus.req_valid = 4'b0011;
    settle();
    chk("mr_ptr_reset", 32'(bus.req_ready), 32'b0001);
    bus.req_valid = '0;
    tick();

    // Response accepted on first cycle; pending req2 granted next cycle
    bus.rsp_ready = 1'b1;
    set_req(0, 4'd3, 4'd4, 2'd0);
    set_req(2, 4'd5, 4'd5, 2'd0);
    bus.req_valid = 4'b0001;
    settle();
    chk("sim_grant0", 32'(bus.req_ready), 32'b0001);
    tick();
    bus.req_valid = 4'b0100;
    tick(); tick();
    settle();
    chk("sim_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("sim_rsp_data",  32'(bus.rsp_data),  32'd7);
    chk("sim_resp_ready", 32'(bus.req_ready), 32'd0);
    tick();
    settle();
    chk("sim_idle",      32'(idle),          32'd1);
    chk("sim_rsp_drop",  32'(bus.rsp_valid), 32'd0);
    chk("sim_grant2",    32'(bus.req_ready), 32'b0100);
    tick();
    bus.req_valid = '0;
    tick(); tick();
    settle();
    chk("sim_r2_data", 32'(bus.rsp_data), 32'd10);
    chk("sim_r2_id",   32'(bus.rsp_id),   32'd2);
    tick();
    bus.rsp_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
